// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline stage register with a 2-entry skid buffer (main + skid).
// in_ready depends only on state flops; flush empties the stage and masks ctrl to a bubble.
module pipe_skid_stage #(
   parameter int                DATA_W      = 128,
   parameter int                CTRL_W      = 24,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = 24'h000008,
   parameter int                NEG_EDGE    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t            state_r;
   logic              clk_act_s;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [CTRL_W-1:0] out_ctrl_r;
   logic [DATA_W-1:0] main_data_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic [DATA_W-1:0] skid_data_r;
   logic [CTRL_W-1:0] skid_ctrl_r;

   // Falling-edge operation keeps the stage half a cycle ahead of posedge neighbours.
   assign clk_act_s = (NEG_EDGE != 0) ? ~clk : clk;

   // Stage FSM: state, storage and registered handshake/ctrl outputs.
   always_ff @(posedge clk_act_s or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_ctrl_r  <= CTRL_BUBBLE;
         main_data_r <= {DATA_W{1'b0}};
         main_ctrl_r <= CTRL_BUBBLE;
         skid_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= CTRL_BUBBLE;
      end else if (flush) begin
         // Held data stays in place; only the state and visible ctrl are killed.
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_ctrl_r  <= CTRL_BUBBLE;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_valid) begin
                  state_r     <= ST_ONE;
                  main_data_r <= in_data;
                  main_ctrl_r <= in_ctrl;
                  out_valid_r <= 1'b1;
                  out_ctrl_r  <= in_ctrl;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r <= ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_valid && out_ready) begin
                  main_data_r <= in_data;
                  main_ctrl_r <= in_ctrl;
                  out_ctrl_r  <= in_ctrl;
               end else if (in_valid) begin
                  state_r     <= ST_TWO;
                  skid_data_r <= in_data;
                  skid_ctrl_r <= in_ctrl;
                  in_ready_r  <= 1'b0;
               end else if (out_ready) begin
                  state_r     <= ST_EMPTY;
                  out_valid_r <= 1'b0;
                  out_ctrl_r  <= CTRL_BUBBLE;
               end else begin
                  state_r <= ST_ONE;
               end
            end
            ST_TWO: begin
               if (out_ready) begin
                  state_r     <= ST_ONE;
                  main_data_r <= skid_data_r;
                  main_ctrl_r <= skid_ctrl_r;
                  out_ctrl_r  <= skid_ctrl_r;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r <= ST_TWO;
               end
            end
            default: begin
               state_r     <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               out_ctrl_r  <= CTRL_BUBBLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_ctrl  = out_ctrl_r;
   assign out_data  = main_data_r;
   assign occupancy = state_r;

endmodule
